// File: rtl/control_unit_pkg.sv
// Shared encodings for the accumulator-machine control unit: opcodes, bus/ALU selects, FSM states.
// CU_ILLEGAL_HALT_EN (when defined) makes undefined opcodes halt instead of acting as NOPs.
package control_unit_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_DECA    = 8'h48;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BCS     = 8'h27;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_INC = 3'b100,
    ALU_DEC = 3'b101
  } alu_sel_t;

  typedef enum logic [1:0] {
    BUS1_PC = 2'b00,
    BUS1_A  = 2'b01,
    BUS1_B  = 2'b10
  } bus1_sel_t;

  typedef enum logic [1:0] {
    BUS2_ALU  = 2'b00,
    BUS2_BUS1 = 2'b01,
    BUS2_MEM  = 2'b10
  } bus2_sel_t;

  // Shared prefix states (OPR_*, BR_*) are reused by several opcodes; IR picks the branch out.
  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_D3,
    S_OPR_MAR, S_OPR_INC,
    S_LDA_IMM, S_LDB_IMM,
    S_DIR_MAR, S_DIR_WAIT, S_LDA_DIR, S_LDB_DIR,
    S_STA_WR, S_STB_WR,
    S_ADD_AB, S_SUB_AB, S_AND_AB, S_OR_AB, S_INCA, S_DECA,
    S_BR_MAR, S_BR_WAIT, S_BR_LOAD, S_BR_SKIP,
    S_HALT
  } state_t;

  function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] ccr);
    case (op)
      OP_BRA:  return 1'b1;
      OP_BMI:  return ccr[FLAG_N];
      OP_BEQ:  return ccr[FLAG_Z];
      OP_BCS:  return ccr[FLAG_C];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control word between the control unit (master) and the datapath/memory (slave).
interface control_unit_if;
  import control_unit_pkg::*;

  // No handshake: the control word is valid every cycle and is consumed at the next rising edge.
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load;
  logic       MAR_Load;
  logic       PC_Load;
  logic       PC_Inc;
  logic       A_Load;
  logic       B_Load;
  logic       CCR_Load;
  alu_sel_t   ALU_Sel;
  bus1_sel_t  Bus1_Sel;
  bus2_sel_t  Bus2_Sel;
  logic       write;

  modport master (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
    output ALU_Sel, Bus1_Sel, Bus2_Sel, write
  );

  modport slave (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
    input  ALU_Sel, Bus1_Sel, Bus2_Sel, write
  );
endinterface

// File: rtl/control_unit.sv
// Moore control unit: state register, next-state logic and output decoder.
// Define CU_ILLEGAL_HALT_EN to halt on undefined opcodes; otherwise they retire as NOPs.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master cu,
  output state_t         dbg_state
);

  state_t state;
  state_t state_next;
  state_t out_state;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_F0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_F0;
    case (state)
      S_F0: state_next = S_F1;
      S_F1: state_next = S_F2;
      S_F2: state_next = S_D3;
      S_D3: begin
        case (cu.IR)
          OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
          OP_STA_DIR, OP_STB_DIR:             state_next = S_OPR_MAR;
          OP_ADD_AB:                          state_next = S_ADD_AB;
          OP_SUB_AB:                          state_next = S_SUB_AB;
          OP_AND_AB:                          state_next = S_AND_AB;
          OP_OR_AB:                           state_next = S_OR_AB;
          OP_INCA:                            state_next = S_INCA;
          OP_DECA:                            state_next = S_DECA;
          OP_BRA, OP_BMI, OP_BEQ, OP_BCS:
            state_next = branch_taken(cu.IR, cu.CCR_Result) ? S_BR_MAR : S_BR_SKIP;
`ifdef CU_ILLEGAL_HALT_EN
          default:                            state_next = S_HALT;
`else
          default:                            state_next = S_F0;
`endif
        endcase
      end
      S_OPR_MAR: state_next = S_OPR_INC;
      S_OPR_INC: begin
        case (cu.IR)
          OP_LDA_IMM: state_next = S_LDA_IMM;
          OP_LDB_IMM: state_next = S_LDB_IMM;
          default:    state_next = S_DIR_MAR;
        endcase
      end
      S_DIR_MAR: begin
        case (cu.IR)
          OP_STA_DIR: state_next = S_STA_WR;
          OP_STB_DIR: state_next = S_STB_WR;
          default:    state_next = S_DIR_WAIT;
        endcase
      end
      S_DIR_WAIT: state_next = (cu.IR == OP_LDA_DIR) ? S_LDA_DIR : S_LDB_DIR;
      S_BR_MAR:   state_next = S_BR_WAIT;
      S_BR_WAIT:  state_next = S_BR_LOAD;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_F0;
    endcase
  end

  // Reset overrides the decoded state so a store caught mid-flight cannot strobe write.
  always_comb begin
    out_state   = reset ? S_F0 : state;
    cu.IR_Load  = 1'b0;
    cu.MAR_Load = 1'b0;
    cu.PC_Load  = 1'b0;
    cu.PC_Inc   = 1'b0;
    cu.A_Load   = 1'b0;
    cu.B_Load   = 1'b0;
    cu.CCR_Load = 1'b0;
    cu.ALU_Sel  = ALU_ADD;
    cu.Bus1_Sel = BUS1_PC;
    cu.Bus2_Sel = BUS2_ALU;
    cu.write    = 1'b0;
    case (out_state)
      S_F0, S_OPR_MAR, S_BR_MAR: begin
        cu.Bus1_Sel = BUS1_PC;
        cu.Bus2_Sel = BUS2_BUS1;
        cu.MAR_Load = 1'b1;
      end
      S_F1, S_OPR_INC, S_BR_SKIP: cu.PC_Inc = 1'b1;
      S_F2: begin
        cu.Bus2_Sel = BUS2_MEM;
        cu.IR_Load  = 1'b1;
      end
      S_LDA_IMM, S_LDA_DIR: begin
        cu.Bus2_Sel = BUS2_MEM;
        cu.A_Load   = 1'b1;
      end
      S_LDB_IMM, S_LDB_DIR: begin
        cu.Bus2_Sel = BUS2_MEM;
        cu.B_Load   = 1'b1;
      end
      S_DIR_MAR: begin
        cu.Bus2_Sel = BUS2_MEM;
        cu.MAR_Load = 1'b1;
      end
      S_STA_WR: begin
        cu.Bus1_Sel = BUS1_A;
        cu.write    = 1'b1;
      end
      S_STB_WR: begin
        cu.Bus1_Sel = BUS1_B;
        cu.write    = 1'b1;
      end
      S_ADD_AB, S_SUB_AB, S_AND_AB, S_OR_AB: begin
        cu.Bus1_Sel = BUS1_B;
        cu.Bus2_Sel = BUS2_ALU;
        cu.A_Load   = 1'b1;
        cu.CCR_Load = 1'b1;
        case (out_state)
          S_SUB_AB: cu.ALU_Sel = ALU_SUB;
          S_AND_AB: cu.ALU_Sel = ALU_AND;
          S_OR_AB:  cu.ALU_Sel = ALU_OR;
          default:  cu.ALU_Sel = ALU_ADD;
        endcase
      end
      S_INCA, S_DECA: begin
        cu.ALU_Sel  = (out_state == S_INCA) ? ALU_INC : ALU_DEC;
        cu.Bus2_Sel = BUS2_ALU;
        cu.A_Load   = 1'b1;
        cu.CCR_Load = 1'b1;
      end
      S_BR_LOAD: begin
        cu.Bus2_Sel = BUS2_MEM;
        cu.PC_Load  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: datapath + memory environment, instruction-level reference model, scoreboard.
// Build with CU_ILLEGAL_HALT_EN to exercise the halt-on-undefined-opcode variant.
module tb_control_unit;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] cycles;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wr_cnt;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
  } rec_t;

  localparam logic [14:0] F0_WORD = 15'b0100000_000_00_01_0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_unit_if cu_if ();
  control_unit_pkg::state_t dbg_state;

  control_unit dut (
    .clk      (clk),
    .reset    (reset),
    .cu       (cu_if),
    .dbg_state(dbg_state)
  );

  // ---------------- datapath + memory environment ----------------
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  dp_pc, dp_mar, dp_ir, dp_a, dp_b, mem_q, bus1, bus2;
  logic [3:0]  dp_ccr;
  logic [11:0] alu_out;
  logic [14:0] ctrl_word;

  function automatic logic [11:0] alu(input int sel, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic v, c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (sel)
      0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      2: r = a & b;
      3: r = a | b;
      4: begin r = a + 8'd1; c = (a == 8'hFF); v = (a == 8'h7F); end
      5: begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
      default: r = 8'h00;
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  assign cu_if.IR         = dp_ir;
  assign cu_if.CCR_Result = dp_ccr;
  assign alu_out = alu(int'(cu_if.ALU_Sel), dp_a, bus1);
  assign ctrl_word = {cu_if.IR_Load, cu_if.MAR_Load, cu_if.PC_Load, cu_if.PC_Inc,
                      cu_if.A_Load, cu_if.B_Load, cu_if.CCR_Load, cu_if.ALU_Sel,
                      cu_if.Bus1_Sel, cu_if.Bus2_Sel, cu_if.write};

  always_comb begin
    case (cu_if.Bus1_Sel)
      2'b00:   bus1 = dp_pc;
      2'b01:   bus1 = dp_a;
      2'b10:   bus1 = dp_b;
      default: bus1 = 8'h00;
    endcase
    case (cu_if.Bus2_Sel)
      2'b00:   bus2 = alu_out[7:0];
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = mem_q;
      default: bus2 = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      dp_pc <= 8'h00; dp_mar <= 8'h00; dp_ir <= 8'h00;
      dp_a <= 8'h00; dp_b <= 8'h00; dp_ccr <= 4'h0; mem_q <= 8'h00;
    end else begin
      mem_q <= mem[dp_mar];
      if (cu_if.write) mem[dp_mar] = bus1;
      if (cu_if.MAR_Load) dp_mar <= bus2;
      if (cu_if.PC_Load) dp_pc <= bus2;
      else if (cu_if.PC_Inc) dp_pc <= dp_pc + 8'd1;
      if (cu_if.IR_Load) dp_ir <= bus2;
      if (cu_if.A_Load) dp_a <= bus2;
      if (cu_if.B_Load) dp_b <= bus2;
      if (cu_if.CCR_Load) dp_ccr <= alu_out[11:8];
    end
  end

  // ---------------- scoreboard ----------------
  int   total = 0;
  int   bad = 0;
  rec_t exp_q[$];
  bit   sb_en = 1'b0;
  bit   have_prev = 1'b0;
  int   cyc = 0;
  int   wr_cnt = 0;
  logic [7:0] wr_addr, wr_data, cur_op, cur_addr;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    check("pc_load_and_inc", int'(cu_if.PC_Load & cu_if.PC_Inc), 0);
    check("write_with_load", int'(cu_if.write & (cu_if.IR_Load | cu_if.MAR_Load | cu_if.PC_Load |
          cu_if.PC_Inc | cu_if.A_Load | cu_if.B_Load | cu_if.CCR_Load)), 0);
    if (reset || !sb_en) begin
      have_prev = 1'b0; cyc = 0; wr_cnt = 0;
    end else begin
      cyc++;
      if (cu_if.write) begin
        wr_cnt++; wr_addr = dp_mar; wr_data = bus1;
      end
      if (cu_if.IR_Load) begin
        if (have_prev && exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check("opcode", int'(cur_op), int'(r.op));
          check("fetch_addr", int'(cur_addr), int'(r.addr));
          check("cycles", cyc, int'(r.cycles));
          check("reg_a", int'(dp_a), int'(r.a));
          check("reg_b", int'(dp_b), int'(r.b));
          check("write_count", wr_cnt, int'(r.wr_cnt));
          if (r.wr_cnt != 0) begin
            check("write_addr", int'(wr_addr), int'(r.wr_addr));
            check("write_data", int'(wr_data), int'(r.wr_data));
          end
        end
        cur_op = mem_q; cur_addr = dp_mar;
        have_prev = 1'b1; cyc = 0; wr_cnt = 0;
      end
    end
  end

  // ---------------- instruction-level reference model ----------------
  task automatic ref_run(input int n);
    logic [7:0]  pc, a, b, op, opnd;
    logic [3:0]  ccr;
    logic [11:0] res;
    logic        taken;
    rec_t        r;
    pc = 8'h00; a = 8'h00; b = 8'h00; ccr = 4'h0;
    for (int i = 0; i < n; i++) begin
      r = '0;
      r.addr = pc; op = ref_mem[pc]; r.op = op; pc = pc + 8'd1; r.cycles = 8'd4;
      case (op)
        8'h86, 8'h88: begin
          opnd = ref_mem[pc]; pc = pc + 8'd1; r.cycles = 8'd7;
          if (op == 8'h86) a = opnd; else b = opnd;
        end
        8'h87, 8'h89: begin
          opnd = ref_mem[pc]; pc = pc + 8'd1; r.cycles = 8'd9;
          if (op == 8'h87) a = ref_mem[opnd]; else b = ref_mem[opnd];
        end
        8'h96, 8'h97: begin
          opnd = ref_mem[pc]; pc = pc + 8'd1; r.cycles = 8'd8;
          r.wr_cnt = 8'd1; r.wr_addr = opnd; r.wr_data = (op == 8'h96) ? a : b;
          ref_mem[opnd] = r.wr_data;
        end
        8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48: begin
          if (op == 8'h46)      res = alu(4, a, 8'h00);
          else if (op == 8'h48) res = alu(5, a, 8'h00);
          else                  res = alu(int'(op) - 'h42, a, b);
          a = res[7:0]; ccr = res[11:8]; r.cycles = 8'd5;
        end
        8'h20, 8'h21, 8'h23, 8'h27: begin
          taken = (op == 8'h20) || (op == 8'h21 && ccr[3]) || (op == 8'h23 && ccr[2]) ||
                  (op == 8'h27 && ccr[0]);
          if (taken) begin pc = ref_mem[pc]; r.cycles = 8'd7; end
          else begin pc = pc + 8'd1; r.cycles = 8'd5; end
        end
        default: ;
      endcase
      r.a = a; r.b = b;
      exp_q.push_back(r);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic run_program(input int n);
    int k;
    ref_mem = mem;
    exp_q.delete();
    ref_run(n);
    @(negedge clk); reset = 1'b1; sb_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < n * 12 + 20) begin
      @(negedge clk); k++;
    end
    check("program_drain", exp_q.size(), 0);
    @(negedge clk); reset = 1'b1; sb_en = 1'b0;
  endtask

  logic [7:0] legal [16] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
                             8'h44, 8'h45, 8'h46, 8'h48, 8'h20, 8'h21, 8'h23, 8'h27};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int loads;
    bit found;
    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_outputs", int'(ctrl_word), int'(F0_WORD));
    @(negedge clk);
    check("reset_outputs_held", int'(ctrl_word), int'(F0_WORD));

    // LDA #5, LDB #3, ADD -> A=8
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h05; mem[2] = 8'h88; mem[3] = 8'h03; mem[4] = 8'h42; mem[5] = 8'h46;
    run_program(3);

    // LDA #2A, STA $80
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h2A; mem[2] = 8'h96; mem[3] = 8'h80; mem[4] = 8'h46;
    run_program(2);

    // BEQ taken (Z=1) and not taken (Z=0)
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h01; mem[2] = 8'h48; mem[3] = 8'h23; mem[4] = 8'h10; mem[16] = 8'h46;
    run_program(4);
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h02; mem[2] = 8'h48; mem[3] = 8'h23; mem[4] = 8'h10; mem[5] = 8'h46;
    run_program(4);

`ifndef CU_ILLEGAL_HALT_EN
    // undefined opcode retires as a NOP
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h07; mem[2] = 8'hFF; mem[3] = 8'h88; mem[4] = 8'h09; mem[5] = 8'h46;
    run_program(3);
`else
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h07; mem[2] = 8'hFF; mem[3] = 8'h88; mem[4] = 8'h09;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    loads = 0;
    repeat (30) begin @(negedge clk); if (cu_if.IR_Load) loads++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cu_if.IR_Load) loads++;
      check("halt_outputs", int'(ctrl_word), 0);
    end
    check("halt_fetch_count", loads, 2);
    reset = 1'b1;
    @(negedge clk);
    check("halt_reset_outputs", int'(ctrl_word), int'(F0_WORD));
    reset = 1'b0;
    @(negedge clk);
    check("halt_exit_f0", int'(ctrl_word), int'(F0_WORD));
    reset = 1'b1;
`endif

    // reset while the store sits in its write cycle
    clear_mem();
    mem[0] = 8'h86; mem[1] = 8'h2A; mem[2] = 8'h96; mem[3] = 8'h80; mem[128] = 8'h55;
    @(negedge clk); reset = 1'b0;
    found = 1'b0; k = 0;
    while (!found && k < 40) begin
      @(negedge clk); k++;
      if (dp_ir == 8'h96 && cu_if.MAR_Load && cu_if.Bus2_Sel == 2'b10) found = 1'b1;
    end
    check("store_addr_phase_seen", int'(found), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_store_write", int'(cu_if.write), 0);
    check("rst_store_f0", int'(ctrl_word), int'(F0_WORD));
    @(negedge clk);
    check("rst_store_f0_next", int'(ctrl_word), int'(F0_WORD));
    reset = 1'b0;
    found = 1'b0; k = 0;
    while (!found && k < 10) begin
      @(negedge clk); k++;
      if (cu_if.write) check("rst_store_no_write", 1, 0);
      if (cu_if.IR_Load) found = 1'b1;
    end
    check("refetch_seen", int'(found), 1);
    check("refetch_addr", int'(dp_mar), 0);
    check("store_target_intact", int'(mem[128]), 8'h55);
    @(negedge clk); reset = 1'b1;

    // random programs
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < 256; i++) begin
`ifdef CU_ILLEGAL_HALT_EN
        mem[i] = legal[$urandom_range(0, 15)];
`else
        mem[i] = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 15)] : 8'($urandom_range(0, 255));
`endif
      end
      run_program(30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
